spi_master: RTL

Initiator end of the team's SPI link: a single-chip-select, mode-0 (CPOL=0, CPHA=0) SPI master that drives SCLK, CS, and MOSI, and samples MISO. It transfers one DATA_WIDTH-bit frame per start request and is the counterpart of the existing SPI slave. It sits between a local parallel requester and the external SPI bus, and derives SCLK from the system clock.

---
 rtl/spi_pkg.sv | 20 ++
 rtl/spi_clk_div.sv | 35 +++
 rtl/spi_master.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI master.
// Bit order is selected by SPI_MASTER_LSB_FIRST_EN in spi_master.sv; nothing here depends on it.
package spi_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;
    localparam int DEFAULT_CLK_DIV    = 2;

    // Chip select is active low on the bus.
    localparam logic CS_ACTIVE = 1'b0;
    localparam logic CS_IDLE   = ~CS_ACTIVE;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        DONE
    } state_e;

endpackage

// File: rtl/spi_clk_div.sv
// SCLK half-period timer for the SPI master.
// half_tick_o pulses for one clk cycle every CLK_DIV enabled cycles. clear_i reloads the
// count so that the first tick after a clear arrives exactly CLK_DIV cycles later.
module spi_clk_div
    import spi_pkg::*;
#(
    parameter int CLK_DIV = DEFAULT_CLK_DIV
) (
    input  logic clk,
    input  logic reset,
    input  logic en_i,
    input  logic clear_i,
    output logic half_tick_o
);

    localparam int            CNT_W  = $clog2(CLK_DIV + 1);
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;

    assign half_tick_o = en_i && (cnt_q == '0);

    // Down-counter: reload on clear or on reaching zero, otherwise count while enabled.
    // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= RELOAD;
        end else if (clear_i) begin
            cnt_q <= RELOAD;
        end else if (en_i) begin
            cnt_q <= (cnt_q == '0) ? RELOAD : cnt_q - 1'b1;
        end
    end

endmodule

// File: rtl/spi_master.sv
// Mode-0 (CPOL=0, CPHA=0) single-chip-select SPI master, one DATA_WIDTH-bit frame per start.
// Build option: define SPI_MASTER_LSB_FIRST_EN to shift LSB-first on both MOSI and MISO;
// otherwise frames are MSB-first. Timing and handshake are the same in both builds.
module spi_master
    import spi_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int CLK_DIV    = DEFAULT_CLK_DIV
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] masterDataToSend,
    output logic [DATA_WIDTH-1:0] masterDataReceived,
    output logic                  busy,
    output logic                  done,
    output logic                  SCLK,
    output logic                  CS,
    output logic                  MOSI,
    input  logic                  MISO
);

    localparam int BIT_W = $clog2(DATA_WIDTH + 1);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_WIDTH);

`ifdef SPI_MASTER_LSB_FIRST_EN
    localparam int LEAD_IDX = 0;
`else
    localparam int LEAD_IDX = DATA_WIDTH - 1;
`endif

    state_e                state_q;
    logic [DATA_WIDTH-1:0] tx_shift_q;
    logic [DATA_WIDTH-1:0] rx_shift_q;
    logic [DATA_WIDTH-1:0] rx_data_q;
    logic [BIT_W-1:0]      bit_cnt_q;
    logic                  sclk_q;
    logic                  cs_q;
    logic                  mosi_q;
    logic                  busy_q;
    logic                  done_q;

    logic [DATA_WIDTH-1:0] tx_shift_d;
    logic [DATA_WIDTH-1:0] rx_shift_d;
    logic                  half_tick;
    logic                  div_en;
    logic                  div_clear;

    // Next shift-register contents: the bit leaving tx is the one already on MOSI,
    // and MISO enters rx from the side that keeps the first received bit at LEAD_IDX.
`ifdef SPI_MASTER_LSB_FIRST_EN
    assign tx_shift_d = {1'b0, tx_shift_q[DATA_WIDTH-1:1]};
    assign rx_shift_d = {MISO, rx_shift_q[DATA_WIDTH-1:1]};
`else
    assign tx_shift_d = {tx_shift_q[DATA_WIDTH-2:0], 1'b0};
    assign rx_shift_d = {rx_shift_q[DATA_WIDTH-2:0], MISO};
`endif

    // The divider only runs while a frame is on the bus and restarts on each accepted start.
    assign div_en    = (state_q == SETUP) || (state_q == SHIFT) || (state_q == HOLD);
    assign div_clear = (state_q == IDLE) && start;

    spi_clk_div #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_div (
        .clk         (clk),
        .reset       (reset),
        .en_i        (div_en),
        .clear_i     (div_clear),
        .half_tick_o (half_tick)
    );

    // Frame sequencer: owns the shift registers and every registered bus/handshake output.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            tx_shift_q <= '0;
            rx_shift_q <= '0;
            rx_data_q  <= '0;
            bit_cnt_q  <= '0;
            sclk_q     <= 1'b0;
            cs_q       <= CS_IDLE;
            mosi_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        tx_shift_q <= masterDataToSend;
                        bit_cnt_q  <= '0;
                        cs_q       <= CS_ACTIVE;
                        busy_q     <= 1'b1;
                        mosi_q     <= masterDataToSend[LEAD_IDX];
                        state_q    <= SETUP;
                    end
                end
                SETUP: begin
                    // First rising SCLK edge: sample MISO as SCLK goes high.
                    if (half_tick) begin
                        sclk_q     <= 1'b1;
                        rx_shift_q <= rx_shift_d;
                        bit_cnt_q  <= bit_cnt_q + 1'b1;
                        state_q    <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (half_tick) begin
                        if (!sclk_q) begin
                            sclk_q     <= 1'b1;
                            rx_shift_q <= rx_shift_d;
                            bit_cnt_q  <= bit_cnt_q + 1'b1;
                        end else begin
                            sclk_q <= 1'b0;
                            if (bit_cnt_q == LAST_BIT) begin
                                state_q <= HOLD;
                            end else begin
                                tx_shift_q <= tx_shift_d;
                                mosi_q     <= tx_shift_d[LEAD_IDX];
                            end
                        end
                    end
                end
                HOLD: begin
                    if (half_tick) begin
                        cs_q      <= CS_IDLE;
                        mosi_q    <= 1'b0;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        rx_data_q <= rx_shift_q;
                        state_q   <= DONE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign SCLK               = sclk_q;
    assign CS                 = cs_q;
    assign MOSI               = (cs_q == CS_ACTIVE) ? mosi_q : 1'bz;
    assign busy               = busy_q;
    assign done               = done_q;
    assign masterDataReceived = rx_data_q;

endmodule
